// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_ctrl_pkg                                                            |
// | Control-bundle layout shared by the decoder and the pipeline stages.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package pipe_ctrl_pkg;

    localparam int EX_W = 3;
    localparam int M_W  = 3;
    localparam int WB_W = 2;

    localparam int EX_REGDST   = 2;
    localparam int EX_ALUOP    = 1;
    localparam int EX_ALUSRC   = 0;
    localparam int M_BRANCH    = 2;
    localparam int M_MEMREAD   = 1;
    localparam int M_MEMWRITE  = 0;
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTORG  = 0;

    localparam logic [EX_W-1:0] EX_NOP = '0;
    localparam logic [M_W-1:0]  M_NOP  = '0;
    localparam logic [WB_W-1:0] WB_NOP = '0;

endpackage
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | load_use_detect                                                          |
// | Flags an ID instruction that reads the destination of a load in EX.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module load_use_detect #(
    parameter int REG_W = 5
) (
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rt,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    output logic             hazard
);

    // $0 is never written, so a load targeting it cannot create a dependency.
    assign hazard = ex_memread & (ex_rt != '0) & ((ex_rt == id_rs) | (ex_rt == id_rt));

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | id_ex_stage                                                              |
// | ID/EX pipeline register with load-use stall, flush, hold, bubble count.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module id_ex_stage
    import pipe_ctrl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [EX_W-1:0]   ex_in,
    input  logic [M_W-1:0]    m_in,
    input  logic [WB_W-1:0]   wb_in,
    input  logic [DATA_W-1:0] pc4_in,
    input  logic [DATA_W-1:0] rd1_in,
    input  logic [DATA_W-1:0] rd2_in,
    input  logic [DATA_W-1:0] imm_in,
    input  logic [REG_W-1:0]  rs_in,
    input  logic [REG_W-1:0]  rt_in,
    input  logic [REG_W-1:0]  rd_in,
    input  logic              flush,
    input  logic              hold,
    output logic [EX_W-1:0]   ex_out,
    output logic [M_W-1:0]    m_out,
    output logic [WB_W-1:0]   wb_out,
    output logic [DATA_W-1:0] pc4_out,
    output logic [DATA_W-1:0] rd1_out,
    output logic [DATA_W-1:0] rd2_out,
    output logic [DATA_W-1:0] imm_out,
    output logic [REG_W-1:0]  rs_out,
    output logic [REG_W-1:0]  rt_out,
    output logic [REG_W-1:0]  rd_out,
    output logic              pc_write,
    output logic              if_id_write,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic [EX_W-1:0]   ex_q,  ex_d;
    logic [M_W-1:0]    m_q,   m_d;
    logic [WB_W-1:0]   wb_q,  wb_d;
    logic [DATA_W-1:0] pc4_q, pc4_d;
    logic [DATA_W-1:0] rd1_q, rd1_d;
    logic [DATA_W-1:0] rd2_q, rd2_d;
    logic [DATA_W-1:0] imm_q, imm_d;
    logic [REG_W-1:0]  rs_q,  rs_d;
    logic [REG_W-1:0]  rt_q,  rt_d;
    logic [REG_W-1:0]  rd_q,  rd_d;
    logic [CNT_W-1:0]  bubble_cnt_q, bubble_cnt_d;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              w_hazard;

    load_use_detect #(
        .REG_W (REG_W)
    ) u_load_use_detect (
        .ex_memread (m_q[M_MEMREAD]),
        .ex_rt      (rt_q),
        .id_rs      (rs_in),
        .id_rt      (rt_in),
        .hazard     (w_hazard)
    );

    assign pc_write    = ~(w_hazard | hold);
    assign if_id_write = ~(w_hazard | hold);

    assign w_cnt_inc = (&bubble_cnt_q) ? bubble_cnt_q : bubble_cnt_q + CNT_W'(1);

    always_comb begin
        ex_d         = ex_in;
        m_d          = m_in;
        wb_d         = wb_in;
        pc4_d        = pc4_in;
        rd1_d        = rd1_in;
        rd2_d        = rd2_in;
        imm_d        = imm_in;
        rs_d         = rs_in;
        rt_d         = rt_in;
        rd_d         = rd_in;
        bubble_cnt_d = bubble_cnt_q;
        if (flush) begin
            ex_d = EX_NOP;
            m_d  = M_NOP;
            wb_d = WB_NOP;
        end else if (hold) begin
            ex_d  = ex_q;
            m_d   = m_q;
            wb_d  = wb_q;
            pc4_d = pc4_q;
            rd1_d = rd1_q;
            rd2_d = rd2_q;
            imm_d = imm_q;
            rs_d  = rs_q;
            rt_d  = rt_q;
            rd_d  = rd_q;
        end else if (w_hazard) begin
            // The stalled instruction is re-presented by IF/ID next cycle.
            ex_d         = EX_NOP;
            m_d          = M_NOP;
            wb_d         = WB_NOP;
            bubble_cnt_d = w_cnt_inc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q         <= '0;
            m_q          <= '0;
            wb_q         <= '0;
            pc4_q        <= '0;
            rd1_q        <= '0;
            rd2_q        <= '0;
            imm_q        <= '0;
            rs_q         <= '0;
            rt_q         <= '0;
            rd_q         <= '0;
            bubble_cnt_q <= '0;
        end else begin
            ex_q         <= ex_d;
            m_q          <= m_d;
            wb_q         <= wb_d;
            pc4_q        <= pc4_d;
            rd1_q        <= rd1_d;
            rd2_q        <= rd2_d;
            imm_q        <= imm_d;
            rs_q         <= rs_d;
            rt_q         <= rt_d;
            rd_q         <= rd_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign ex_out     = ex_q;
    assign m_out      = m_q;
    assign wb_out     = wb_q;
    assign pc4_out    = pc4_q;
    assign rd1_out    = rd1_q;
    assign rd2_out    = rd2_q;
    assign imm_out    = imm_q;
    assign rs_out     = rs_q;
    assign rt_out     = rt_q;
    assign rd_out     = rd_q;
    assign bubble_cnt = bubble_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_id_ex_stage                                                           |
// | Directed vectors for id_ex_stage, plus hold/reset/saturation sequences.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  ex_in = '0, m_in = '0;
    logic [1:0]  wb_in = '0;
    logic [31:0] pc4_in = '0, rd1_in = '0, rd2_in = '0, imm_in = '0;
    logic [4:0]  rs_in = '0, rt_in = '0, rd_in = '0;
    logic        flush = 1'b0, hold = 1'b0;

    logic [2:0]  ex_out, m_out;
    logic [1:0]  wb_out;
    logic [31:0] pc4_out, rd1_out, rd2_out, imm_out;
    logic [4:0]  rs_out, rt_out, rd_out;
    logic        pc_write, if_id_write;
    logic [15:0] bubble_cnt;

    logic [2:0]  ex_s, m_s;
    logic [1:0]  wb_s;
    logic [31:0] pc4_s, rd1_s, rd2_s, imm_s;
    logic [4:0]  rs_s, rt_s, rd_s;
    logic        pcw_s, ifw_s;
    logic [2:0]  cnt_s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(32), .REG_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .ex_in(ex_in), .m_in(m_in), .wb_in(wb_in),
        .pc4_in(pc4_in), .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in),
        .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in), .flush(flush), .hold(hold),
        .ex_out(ex_out), .m_out(m_out), .wb_out(wb_out), .pc4_out(pc4_out),
        .rd1_out(rd1_out), .rd2_out(rd2_out), .imm_out(imm_out), .rs_out(rs_out),
        .rt_out(rt_out), .rd_out(rd_out), .pc_write(pc_write),
        .if_id_write(if_id_write), .bubble_cnt(bubble_cnt)
    );

    // Narrow-counter copy sharing the same stimulus, used to reach saturation quickly.
    id_ex_stage #(.DATA_W(32), .REG_W(5), .CNT_W(3)) dut_s (
        .clk(clk), .rst_n(rst_n), .ex_in(ex_in), .m_in(m_in), .wb_in(wb_in),
        .pc4_in(pc4_in), .rd1_in(rd1_in), .rd2_in(rd2_in), .imm_in(imm_in),
        .rs_in(rs_in), .rt_in(rt_in), .rd_in(rd_in), .flush(flush), .hold(hold),
        .ex_out(ex_s), .m_out(m_s), .wb_out(wb_s), .pc4_out(pc4_s),
        .rd1_out(rd1_s), .rd2_out(rd2_s), .imm_out(imm_s), .rs_out(rs_s),
        .rt_out(rt_s), .rd_out(rd_s), .pc_write(pcw_s),
        .if_id_write(ifw_s), .bubble_cnt(cnt_s)
    );

    typedef struct {
        logic [2:0]  ex;
        logic [2:0]  m;
        logic [1:0]  wb;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] rd1;
        logic        fl;
        logic        e_pcw;
        logic [2:0]  e_ex;
        logic [2:0]  e_m;
        logic [1:0]  e_wb;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [2:0] ex, input logic [2:0] m, input logic [1:0] wb,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] rd1);
        ex_in  = ex;
        m_in   = m;
        wb_in  = wb;
        rs_in  = rs;
        rt_in  = rt;
        rd_in  = rd;
        rd1_in = rd1;
        pc4_in = rd1 + 32'd4;
        rd2_in = ~rd1;
        imm_in = rd1 << 1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ctrl"}, {24'd0, ex_out, m_out, wb_out}, 32'd0);
        chk({tag, "_data"}, pc4_out | rd1_out | rd2_out | imm_out, 32'd0);
        chk({tag, "_spec"}, {17'd0, rs_out, rt_out, rd_out}, 32'd0);
        chk({tag, "_cnt"}, {16'd0, bubble_cnt}, 32'd0);
    endtask

    logic [31:0] snap_data;
    logic [7:0]  snap_ctrl;

    initial begin
        //          ex      m       wb     rs  rt  rd  rd1     fl  pcw  e_ex    e_m     e_wb   cnt
        vecs[0]  = '{3'b110, 3'b000, 2'b10, 8,  9,  10, 32'h11, 0,  1,   3'b110, 3'b000, 2'b10, 0};
        vecs[1]  = '{3'b001, 3'b010, 2'b11, 1,  9,  0,  32'h12, 0,  1,   3'b001, 3'b010, 2'b11, 0};
        vecs[2]  = '{3'b110, 3'b000, 2'b10, 9,  3,  4,  32'h22, 0,  0,   3'b000, 3'b000, 2'b00, 1};
        vecs[3]  = '{3'b110, 3'b000, 2'b10, 9,  3,  4,  32'h22, 0,  1,   3'b110, 3'b000, 2'b10, 1};
        vecs[4]  = '{3'b001, 3'b010, 2'b11, 2,  0,  0,  32'h33, 0,  1,   3'b001, 3'b010, 2'b11, 1};
        vecs[5]  = '{3'b110, 3'b000, 2'b10, 0,  0,  6,  32'h44, 0,  1,   3'b110, 3'b000, 2'b10, 1};
        vecs[6]  = '{3'b001, 3'b010, 2'b11, 1,  5,  0,  32'h55, 0,  1,   3'b001, 3'b010, 2'b11, 1};
        vecs[7]  = '{3'b110, 3'b000, 2'b10, 6,  7,  8,  32'h66, 0,  1,   3'b110, 3'b000, 2'b10, 1};
        vecs[8]  = '{3'b001, 3'b010, 2'b11, 1,  12, 0,  32'h77, 0,  1,   3'b001, 3'b010, 2'b11, 1};
        vecs[9]  = '{3'b110, 3'b000, 2'b10, 3,  12, 13, 32'h88, 1,  0,   3'b000, 3'b000, 2'b00, 1};
        vecs[10] = '{3'b110, 3'b101, 2'b10, 1,  2,  3,  32'h99, 0,  1,   3'b110, 3'b101, 2'b10, 1};
        vecs[11] = '{3'b001, 3'b010, 2'b11, 1,  9,  0,  32'hAA, 0,  1,   3'b001, 3'b010, 2'b11, 1};

        #3;
        check_all_zero("reset");
        chk("reset_pcw", {31'd0, pc_write}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            drive(vecs[i].ex, vecs[i].m, vecs[i].wb, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].rd1);
            flush = vecs[i].fl;
            #1;
            chk($sformatf("v%0d_pc_write", i), {31'd0, pc_write}, {31'd0, vecs[i].e_pcw});
            chk($sformatf("v%0d_if_id_write", i), {31'd0, if_id_write}, {31'd0, vecs[i].e_pcw});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_ctrl", i), {24'd0, ex_out, m_out, wb_out},
                {24'd0, vecs[i].e_ex, vecs[i].e_m, vecs[i].e_wb});
            chk($sformatf("v%0d_spec", i), {17'd0, rs_out, rt_out, rd_out},
                {17'd0, vecs[i].rs, vecs[i].rt, vecs[i].rd});
            chk($sformatf("v%0d_rd1", i), rd1_out, vecs[i].rd1);
            chk($sformatf("v%0d_pc4", i), pc4_out, vecs[i].rd1 + 32'd4);
            chk($sformatf("v%0d_rd2_imm", i), rd2_out ^ imm_out, ~vecs[i].rd1 ^ (vecs[i].rd1 << 1));
            chk($sformatf("v%0d_cnt", i), {16'd0, bubble_cnt}, {16'd0, vecs[i].e_cnt});
        end
        flush = 1'b0;

        // lw (rt=9) is in EX; present a dependent add under hold for 3 cycles.
        @(negedge clk);
        drive(3'b110, 3'b000, 2'b10, 9, 4, 5, 32'hBB);
        hold = 1'b1;
        snap_ctrl = {ex_out, m_out, wb_out};
        snap_data = rd1_out;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("hold%0d_pcw", c), {31'd0, pc_write}, 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("hold%0d_ctrl", c), {24'd0, ex_out, m_out, wb_out}, {24'd0, 8'b001_010_11});
            chk($sformatf("hold%0d_rd1", c), rd1_out, 32'hAA);
            chk($sformatf("hold%0d_cnt", c), {16'd0, bubble_cnt}, 32'd1);
            @(negedge clk);
        end
        hold = 1'b0;
        #1;
        chk("unhold_pcw", {31'd0, pc_write}, 32'd0);
        @(posedge clk);
        #1;
        chk("unhold_bubble_ctrl", {24'd0, ex_out, m_out, wb_out}, 32'd0);
        chk("unhold_bubble_cnt", {16'd0, bubble_cnt}, 32'd2);
        @(negedge clk);
        #1;
        chk("unhold_resume_pcw", {31'd0, pc_write}, 32'd1);
        @(posedge clk);
        #1;
        chk("unhold_add_ctrl", {24'd0, ex_out, m_out, wb_out}, {24'd0, 8'b110_000_10});
        chk("unhold_add_cnt", {16'd0, bubble_cnt}, 32'd2);
        chk("snap_used", {24'd0, snap_ctrl} ^ snap_data, 32'h0000_00AA ^ {24'd0, 8'b001_010_11});

        // Asynchronous reset pulse between edges with an R-type loaded.
        @(negedge clk);
        drive(3'b110, 3'b000, 2'b10, 8, 9, 10, 32'hCC);
        @(posedge clk);
        #1;
        chk("pre_rst_ex", {29'd0, ex_out}, 32'd6);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("midrst");
        chk("midrst_cnt_s", {29'd0, cnt_s}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Repeated load-use pairs: narrow counter saturates at 7, wide keeps counting.
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            drive(3'b001, 3'b010, 2'b11, 1, 9, 0, 32'h100 + k);
            @(negedge clk);
            drive(3'b110, 3'b000, 2'b10, 9, 2, 3, 32'h200 + k);
            @(negedge clk);
            chk($sformatf("sat%0d_wide", k), {16'd0, bubble_cnt}, k + 1);
            chk($sformatf("sat%0d_narrow", k), {29'd0, cnt_s}, (k + 1 > 7) ? 32'd7 : k + 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage directly downstream of the opcode control decoder.
- Registers the EX/M/WB control bundles plus decode-stage data into the EX stage.
- Detects load-use hazards against the instruction in EX. On a hazard it inserts a bubble and drives the PC/IF-ID write enables.
- Accepts a branch flush and a global hold, and counts inserted bubbles.

Parameters:
DATA_W, 32, width of PC+4, register operands and sign-extended immediate
REG_W, 5, register specifier width
CNT_W, 16, bubble counter width

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
ex_in  in  3  {RegDst, ALUOp, ALUSrc} from control decoder
m_in  in  3  {Branch, MemRead, MemWrite} from control decoder
wb_in  in  2  {RegWrite, MemtoReg} from control decoder
pc4_in  in  DATA_W  PC+4 of the ID instruction
rd1_in  in  DATA_W  register file read data 1
rd2_in  in  DATA_W  register file read data 2
imm_in  in  DATA_W  sign-extended immediate
rs_in  in  REG_W  ID instruction rs field
rt_in  in  REG_W  ID instruction rt field
rd_in  in  REG_W  ID instruction rd field
flush  in  1  branch taken; kill the ID instruction
hold  in  1  global freeze (e.g. memory not ready)
ex_out, m_out, wb_out  out  3/3/2  registered control bundles
pc4_out, rd1_out, rd2_out, imm_out  out  DATA_W  registered data
rs_out, rt_out, rd_out  out  REG_W  registered specifiers
pc_write  out  1  combinational; 0 freezes the PC
if_id_write  out  1  combinational; 0 freezes the IF/ID register
bubble_cnt  out  CNT_W  saturating count of hazard bubbles

Behaviour:
- Reset (rst_n=0, asynchronous): all registered outputs are 0, including the control bundles, data, specifiers and bubble_cnt. This makes EX a NOP. Release is synchronous to the next clk edge.
- Hazard (combinational): hazard = m_out[MemRead] & (rt_out != 0) & ((rt_out == rs_in) | (rt_out == rt_in)).
- Write enables: pc_write = if_id_write = ~(hazard | hold). flush does not assert them; the upstream redirect handles the PC.
- Priority per rising edge, highest first:
  1. flush: control bundles load 0. Data and specifiers load the inputs; their values are don't-care. bubble_cnt is unchanged.
  2. hold: every register keeps its value.
  3. hazard: control bundles load 0 (bubble). Data and specifiers load the inputs. bubble_cnt increments and saturates at all-ones.
  4. Otherwise: all registers load their inputs verbatim. X bits from the decoder pass through unchanged.
- Latency: one cycle from ID inputs to EX outputs.
- A hazard lasts exactly one cycle under normal flow. After the bubble, m_out[MemRead] is 0, so the stalled instruction loads on the next edge.
- Hold during a hazard: the lw stays in EX, hazard stays asserted and the bubble count does not advance. When hold drops, exactly one bubble is inserted.
- flush together with hazard: flush wins and no count is taken. pc_write and if_id_write still follow the hazard term in that cycle.
- rt_out = 0 with MemRead = 1: no hazard, because $0 is never written.
- Counter wrap: none. It stays at 2^CNT_W-1.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - Bundle bit indices: EX_REGDST=2, EX_ALUOP=1, EX_ALUSRC=0; M_BRANCH=2, M_MEMREAD=1, M_MEMWRITE=0; WB_REGWRITE=1, WB_MEMTORG=0.
  - Bundle widths EX_W=3, M_W=3, WB_W=2.
  - NOP bundle constants, all zero.
- The package is shared with the control decoder and the EX/MEM and MEM/WB stages.
- Sub-module: load_use_detect, combinational. Inputs are ex_memread, ex_rt, id_rs and id_rt; output is hazard.
- The pipeline registers and the counter stay in id_ex_stage.

Test Plan:
- Reset mid-stream: pulse rst_n low between clock edges while ex_in=3'b110 is loaded -> all outputs 0 immediately, asynchronously, and bubble_cnt=0.
- R-type flow: ex_in=110, m_in=000, wb_in=10, rs=8, rt=9, rd=10, rd1=0x11 -> next edge ex_out=110, wb_out=10, rd_out=10, rd1_out=0x11; pc_write=1.
- Load-use: lw with rt=9 (m_in=010) loaded, then add with rs_in=9 -> pc_write=if_id_write=0 for one cycle. Next edge m_out=000, wb_out=00, bubble_cnt=1. The following edge loads the add.
- $0 and no-dependency: lw with rt=0 followed by rs_in=0, then lw with rt=5 followed by rs=6/rt=7 -> no stall and bubble_cnt unchanged in both cases.
- Flush vs hazard vs hold: flush=1 with a pending hazard -> controls 0 and bubble_cnt unchanged. hold=1 for 3 cycles -> all outputs frozen and pc_write=0. Hazard under hold -> a single bubble after hold drops.
- Counter saturation: preload the counter to 0xFFFE through 2 hazards with CNT_W=16, using a forced bench start -> stays at 0xFFFF after further hazards.
